// File: rtl/regfile_mp_bypass_if.sv
// rtl/regfile_mp_bypass_if.sv - write, busy-set and read bus bundle for regfile_mp_bypass
interface regfile_mp_bypass_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int NUM_RD = 2
);
  logic                     wa_en;
  logic [ADDR_W-1:0]        wa_addr;
  logic [DATA_W/8-1:0]      wa_be;
  logic [DATA_W-1:0]        wa_data;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W/8-1:0]      wb_be;
  logic [DATA_W-1:0]        wb_data;
  logic                     bs_en;
  logic [ADDR_W-1:0]        bs_addr;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_collide;

  modport master (
    output wa_en, wa_addr, wa_be, wa_data,
    output wb_en, wb_addr, wb_be, wb_data,
    output bs_en, bs_addr, rd_addr,
    input  rd_data, rd_busy, wr_collide
  );

  modport slave (
    input  wa_en, wa_addr, wa_be, wa_data,
    input  wb_en, wb_addr, wb_be, wb_data,
    input  bs_en, bs_addr, rd_addr,
    output rd_data, rd_busy, wr_collide
  );
endinterface

// File: rtl/regfile_mp_bypass.sv
// rtl/regfile_mp_bypass.sv - multi-port register file with byte-enabled writes, bypass and busy scoreboard
// Port B beats port A per byte; busy-set beats a same-cycle writeback clear.
module regfile_mp_bypass #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_mp_bypass_if.slave   bus
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_busy;
  logic                     r_collide;

  logic                     w_wa_eff;
  logic                     w_wb_eff;
  logic                     w_bs_ok;
  logic                     w_collide;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;
  logic [NUM_RD-1:0]        w_rd_busy;

  // Gated by rst so nothing leaks through the bypass path while in reset.
  assign w_wa_eff = rst && bus.wa_en && (int'(bus.wa_addr) < DEPTH) &&
                    !(ZERO_REG != 0 && bus.wa_addr == '0) && (bus.wa_be != '0);
  assign w_wb_eff = rst && bus.wb_en && (int'(bus.wb_addr) < DEPTH) &&
                    !(ZERO_REG != 0 && bus.wb_addr == '0) && (bus.wb_be != '0);
  assign w_bs_ok  = bus.bs_en && (int'(bus.bs_addr) < DEPTH) &&
                    !(ZERO_REG != 0 && bus.bs_addr == '0);
  assign w_collide = w_wa_eff && w_wb_eff && (bus.wa_addr == bus.wb_addr) &&
                     ((bus.wa_be & bus.wb_be) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < DEPTH; r++) r_mem[r] <= '0;
      r_busy    <= '0;
      r_collide <= 1'b0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        for (int b = 0; b < NB; b++) begin
          if (w_wb_eff && bus.wb_addr == ADDR_W'(r) && bus.wb_be[b])
            r_mem[r][b*8 +: 8] <= bus.wb_data[b*8 +: 8];
          else if (w_wa_eff && bus.wa_addr == ADDR_W'(r) && bus.wa_be[b])
            r_mem[r][b*8 +: 8] <= bus.wa_data[b*8 +: 8];
        end
        if (w_bs_ok && bus.bs_addr == ADDR_W'(r))
          r_busy[r] <= 1'b1;
        else if ((w_wa_eff && bus.wa_addr == ADDR_W'(r)) ||
                 (w_wb_eff && bus.wb_addr == ADDR_W'(r)))
          r_busy[r] <= 1'b0;
      end
      if (w_collide) r_collide <= 1'b1;
    end
  end

  // Out-of-range and hardwired-zero addresses match no entry and read as 0.
  always_comb begin
    w_rd_data = '0;
    w_rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      for (int r = 0; r < DEPTH; r++) begin
        if (bus.rd_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(r) && !(ZERO_REG != 0 && r == 0)) begin
          for (int b = 0; b < NB; b++) begin
            if (BYPASS != 0 && w_wb_eff && bus.wb_addr == ADDR_W'(r) && bus.wb_be[b])
              w_rd_data[k*DATA_W + b*8 +: 8] = bus.wb_data[b*8 +: 8];
            else if (BYPASS != 0 && w_wa_eff && bus.wa_addr == ADDR_W'(r) && bus.wa_be[b])
              w_rd_data[k*DATA_W + b*8 +: 8] = bus.wa_data[b*8 +: 8];
            else
              w_rd_data[k*DATA_W + b*8 +: 8] = r_mem[r][b*8 +: 8];
          end
          w_rd_busy[k] = r_busy[r] &&
                         !(BYPASS != 0 && ((w_wa_eff && bus.wa_addr == ADDR_W'(r)) ||
                                           (w_wb_eff && bus.wb_addr == ADDR_W'(r))));
        end
      end
    end
  end

  assign bus.rd_data    = w_rd_data;
  assign bus.rd_busy    = w_rd_busy;
  assign bus.wr_collide = r_collide;
endmodule

// File: tb/tb_regfile_mp_bypass.sv
// tb/tb_regfile_mp_bypass.sv - directed scoreboard bench; dut_b has BYPASS=1, dut_n BYPASS=0, both DEPTH=24
module tb_regfile_mp_bypass;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        wa_en, wb_en, bs_en;
  logic [4:0]  wa_addr, wb_addr, bs_addr, rd0, rd1;
  logic [3:0]  wa_be, wb_be;
  logic [31:0] wa_data, wb_data;

  regfile_mp_bypass_if #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2)) ifb ();
  regfile_mp_bypass_if #(.ADDR_W(5), .DATA_W(32), .NUM_RD(2)) ifn ();

  assign ifb.wa_en = wa_en;   assign ifn.wa_en = wa_en;
  assign ifb.wa_addr = wa_addr; assign ifn.wa_addr = wa_addr;
  assign ifb.wa_be = wa_be;   assign ifn.wa_be = wa_be;
  assign ifb.wa_data = wa_data; assign ifn.wa_data = wa_data;
  assign ifb.wb_en = wb_en;   assign ifn.wb_en = wb_en;
  assign ifb.wb_addr = wb_addr; assign ifn.wb_addr = wb_addr;
  assign ifb.wb_be = wb_be;   assign ifn.wb_be = wb_be;
  assign ifb.wb_data = wb_data; assign ifn.wb_data = wb_data;
  assign ifb.bs_en = bs_en;   assign ifn.bs_en = bs_en;
  assign ifb.bs_addr = bs_addr; assign ifn.bs_addr = bs_addr;
  assign ifb.rd_addr = {rd1, rd0};
  assign ifn.rd_addr = {rd1, rd0};

  regfile_mp_bypass #(.ADDR_W(5), .DATA_W(32), .DEPTH(24), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  regfile_mp_bypass #(.ADDR_W(5), .DATA_W(32), .DEPTH(24), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
    dut_n (.clk(clk), .rst(rst), .bus(ifn.slave));

  typedef struct {
    string       tag;
    int          dut;   // 0: bypass, 1: non-bypass
    int          sig;   // 0: rd_data, 1: rd_busy, 2: wr_collide
    int          port;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [31:0] observe(int d, int s, int p);
    logic [63:0] data;
    logic [1:0]  busy;
    logic        col;
    data = (d == 0) ? ifb.rd_data : ifn.rd_data;
    busy = (d == 0) ? ifb.rd_busy : ifn.rd_busy;
    col  = (d == 0) ? ifb.wr_collide : ifn.wr_collide;
    if (s == 0) return data[p*32 +: 32];
    if (s == 1) return {31'b0, busy[p]};
    return {31'b0, col};
  endfunction

  task automatic expect1(input string tag, input int d, input int s, input int p, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.dut = d; e.sig = s; e.port = p; e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect2(input string tag, input int s, input int p, input logic [31:0] v);
    expect1(tag, 0, s, p, v);
    expect1(tag, 1, s, p, v);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.dut, e.sig, e.port);
      checks++;
      assert (o === e.val) else begin
        failures++;
        $error("FAIL %s dut%0d observed=%h expected=%h", e.tag, e.dut, o, e.val);
      end
    end
  endtask

  task automatic clear();
    wa_en = 0; wa_addr = 0; wa_be = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_be = 0; wb_data = 0;
    bs_en = 0; bs_addr = 0;
  endtask

  task automatic wr_a(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wa_en = 1; wa_addr = a; wa_be = be; wa_data = d;
  endtask

  task automatic wr_b(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wb_en = 1; wb_addr = a; wb_be = be; wb_data = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    clear();
  endtask

  initial begin
    rst = 1'b0;
    clear();
    rd0 = 5; rd1 = 0;
    @(posedge clk);
    @(negedge clk);
    expect2("rst_data", 0, 0, 32'h0);
    expect2("rst_busy", 1, 0, 32'h0);
    expect2("rst_col", 2, 0, 32'h0);
    drain();
    @(posedge clk); #1 rst = 1'b1;

    // byte enables
    wr_a(3, 4'hF, 32'hFFFFFFFF); tick();
    wr_a(3, 4'b0101, 32'h11223344); rd0 = 3;
    @(negedge clk);
    expect1("be_same_cycle", 0, 0, 0, 32'hFF22FF44);
    expect1("be_same_cycle", 1, 0, 0, 32'hFFFFFFFF);
    drain();
    tick(); @(negedge clk);
    expect2("be_after", 0, 0, 32'hFF22FF44);
    drain();

    // collision
    tick();
    wr_a(7, 4'hF, 32'hAAAAAAAA); wr_b(7, 4'b0011, 32'h0000BBBB); rd1 = 7;
    @(negedge clk);
    expect1("col_bypass", 0, 0, 1, 32'hAAAABBBB);
    expect1("col_bypass", 1, 0, 1, 32'h0);
    expect2("col_before", 2, 0, 32'h0);
    drain();
    tick(); @(negedge clk);
    expect2("col_data", 0, 1, 32'hAAAABBBB);
    expect2("col_set", 2, 0, 32'h1);
    drain();
    tick(); tick(); @(negedge clk);
    expect2("col_sticky", 2, 0, 32'h1);
    drain();

    // bypass
    tick();
    wr_a(9, 4'hF, 32'h1); tick();
    wr_a(9, 4'hF, 32'h55); rd1 = 9;
    @(negedge clk);
    expect1("byp_same", 0, 0, 1, 32'h55);
    expect1("byp_same", 1, 0, 1, 32'h1);
    drain();
    tick(); @(negedge clk);
    expect2("byp_next", 0, 1, 32'h55);
    drain();

    // busy scoreboard
    tick();
    bs_en = 1; bs_addr = 4; rd0 = 4;
    @(negedge clk);
    expect2("bs_same", 1, 0, 32'h0);
    drain();
    tick(); @(negedge clk);
    expect2("bs_next", 1, 0, 32'h1);
    drain();
    tick();
    bs_en = 1; bs_addr = 4; wr_b(4, 4'hF, 32'h4444);
    @(negedge clk);
    expect1("bs_wr_same", 0, 1, 0, 32'h0);
    expect1("bs_wr_same", 1, 1, 0, 32'h1);
    drain();
    tick(); @(negedge clk);
    expect2("bs_wins", 1, 0, 32'h1);
    drain();
    tick();
    wr_a(4, 4'b0001, 32'h9);
    @(negedge clk);
    expect1("clr_same", 0, 1, 0, 32'h0);
    expect1("clr_same", 1, 1, 0, 32'h1);
    drain();
    tick(); @(negedge clk);
    expect2("clr_next", 1, 0, 32'h0);
    expect2("r4_data", 0, 0, 32'h4409);
    drain();

    // zero register and out-of-range
    tick();
    wr_a(0, 4'hF, 32'hDEAD); wr_b(30, 4'hF, 32'hBEEF); bs_en = 1; bs_addr = 0;
    rd0 = 0; rd1 = 30;
    @(negedge clk);
    expect2("zero_same", 0, 0, 32'h0);
    expect2("oor_same", 0, 1, 32'h0);
    drain();
    tick(); @(negedge clk);
    expect2("zero_data", 0, 0, 32'h0);
    expect2("zero_busy", 1, 0, 32'h0);
    expect2("oor_data", 0, 1, 32'h0);
    expect2("oor_busy", 1, 1, 32'h0);
    drain();
    rd0 = 3; rd1 = 7;
    #1;
    expect2("keep_r3", 0, 0, 32'hFF22FF44);
    expect2("keep_r7", 0, 1, 32'hAAAABBBB);
    drain();
    tick();
    wr_a(23, 4'hF, 32'h23); wr_b(24, 4'hF, 32'h24);
    tick(); rd0 = 23; rd1 = 24;
    @(negedge clk);
    expect2("top_valid", 0, 0, 32'h23);
    expect2("first_oor", 0, 1, 32'h0);
    drain();

    // asynchronous reset mid-cycle
    tick();
    wr_a(5, 4'hF, 32'h12345678); bs_en = 1; bs_addr = 6;
    tick(); rd0 = 5; rd1 = 6;
    @(negedge clk);
    expect2("pre_rst_r5", 0, 0, 32'h12345678);
    expect2("pre_rst_busy6", 1, 1, 32'h1);
    drain();
    tick();
    wr_a(5, 4'hF, 32'hCAFEF00D); bs_en = 1; bs_addr = 7;
    #2 rst = 1'b0;
    #1;
    expect2("rst_async_data", 0, 0, 32'h0);
    expect2("rst_async_busy", 1, 1, 32'h0);
    expect2("rst_async_col", 2, 0, 32'h0);
    drain();
    @(posedge clk); #1;
    expect2("rst_hold_data", 0, 0, 32'h0);
    drain();
    rst = 1'b1;
    clear();
    rd1 = 7;
    @(negedge clk);
    expect2("post_rst_r5", 0, 0, 32'h0);
    expect2("post_rst_busy7", 1, 1, 32'h0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_mp_bypass.md
# regfile_mp_bypass

Parametrised multi-port register file for the next-generation MIPS datapath. Supports a configurable number of combinational read ports, two byte-enabled write ports with defined collision priority, optional write-to-read bypass, an optional hardwired-zero register and a per-register busy scoreboard for load-use and multi-cycle hazard detection. Sits between decode (reads, busy set) and writeback (writes, busy clear).

## Interface
- ADDR_W, 5, register address width
- DATA_W, 32, register width; multiple of 8
- DEPTH, 32, number of registers; DEPTH <= 2**ADDR_W
- NUM_RD, 2, number of read ports; 1..4
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1: same-cycle write data and busy-clear visible on read ports
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- wa_en  in  1  write port A enable
- wa_addr  in  ADDR_W  write port A address
- wa_be  in  DATA_W/8  write port A byte enables
- wa_data  in  DATA_W  write port A data
- wb_en, wb_addr, wb_be, wb_data  in  as port A  write port B (higher priority)
- bs_en  in  1  busy-set enable (producer issued)
- bs_addr  in  ADDR_W  busy-set address
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k register has an outstanding producer
- wr_collide  out  1  registered, sticky: A and B wrote same byte of same register in one cycle

## Operation
- Write port X is effective when X_en=1, X_addr < DEPTH, X_addr != 0 (if ZERO_REG) and X_be != 0; otherwise no state change.
- On rising clk, each enabled byte i of an effective write updates byte i of the addressed register; bytes with be=0 retain value.
- Same address, both effective: per byte, B wins where wb_be[i]=1, A applies where only wa_be[i]=1. If any byte has both enables set, wr_collide sets to 1; it clears only on reset.
- Busy: one bit per register. Any effective write clears busy[addr] (either port). bs_en with valid address (< DEPTH, not zero reg) sets busy[bs_addr]. Set and clear of the same register in the same cycle: set wins (new producer).
- Read port k, BYPASS=0: rd_data = stored register; rd_busy = stored busy bit.
- Read port k, BYPASS=1: rd_data = stored value merged per byte with this cycle's effective writes to rd_addr (same A/B priority); rd_busy = stored busy AND NOT cleared by an effective write this cycle. bs_en this cycle does not affect rd_busy until next cycle.
- rd_addr >= DEPTH, or 0 with ZERO_REG=1: rd_data = 0, rd_busy = 0.
- Read ports independent; any number may address the same register.

## Timing
- Reads and rd_busy combinational from rd_addr, state and (BYPASS=1) write/clear inputs; zero cycles.
- Writes, busy updates, wr_collide: one clk edge; visible on non-bypassed reads the cycle after.
- rst low: immediately, asynchronously, all registers 0, all busy 0, wr_collide 0; hence rd_data = 0, rd_busy = 0 for every port. Writes and bs_en ignored while rst low; first update on first rising clk after rst deasserts.
- Reset mid-operation discards any in-flight write of that cycle.

## Test plan
- Reset: preload r5=0x12345678, assert rst low mid-cycle -> rd_data for r5 = 0 before next edge, rd_busy 0, wr_collide 0.
- Byte enables: write r3=0xFFFFFFFF, then wa_be=0b0101, wa_data=0x11223344 -> r3 = 0xFF22FF44.
- Collision: wa r7 be=0b1111 data=0xAAAAAAAA, wb r7 be=0b0011 data=0x0000BBBB same cycle -> r7 = 0xAAAABBBB, wr_collide = 1 next cycle and stays 1.
- Bypass: BYPASS=1, r9=0x1, write r9=0x55 with rd_addr port1=9 same cycle -> rd_data port1 = 0x55 that cycle; BYPASS=0 -> 0x1 that cycle, 0x55 next.
- Scoreboard: bs_en r4 -> rd_busy=1 next cycle; bs_en r4 and write r4 same cycle -> busy stays 1; write r4 alone -> rd_busy 0 same cycle (BYPASS=1), next cycle (BYPASS=0).
- Zero/out-of-range: DEPTH=24, write r0=0xDEAD and r30=0xBEEF, bs_en r0 -> reads of r0 and r30 return 0, rd_busy 0; no other register changes.
